// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the single-port RAM arbiter.
//   rd_own_e : which port owns the read data returning from the RAM next cycle
//   *_DEF    : default parameter values used by mem_arbiter
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 30;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DLOAD  = 2'd2
  } rd_own_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: counts consecutive data grants taken while fetch is
// waiting, and raises fire once STARVE_LIMIT of them have happened so the
// next contested cycle goes to fetch. Only built with MEM_ARB_STARVE_EN.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   i_req        : fetch request
//   i_gnt, d_gnt : grants issued this cycle
//   fire         : limit reached, fetch must win the next contested cycle
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic fire
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt || !i_req) begin
      cnt_d = '0;
    end else if (d_gnt && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read RAM between the
// instruction-fetch port (i_*) and the load/store port (d_*). At most one
// access per cycle; data wins contention. Read data returns one cycle after
// the grant on the port that issued it.
// Build option: define MEM_ARB_STARVE_EN to bound how many consecutive data
// grants may be taken while fetch waits (STARVE_LIMIT); otherwise strict
// data priority and STARVE_LIMIT has no effect.
// Ports:
//   clock, reset              : system clock, synchronous active-high reset
//   i_req/i_addr              : fetch request and word address
//   i_gnt/i_rvalid/i_rdata    : fetch accept (comb), data valid, data
//   d_req/d_we/d_addr/d_wdata : load/store request, command, address, data
//   d_gnt/d_rvalid/d_rdata    : data accept (comb), load valid, load data
//   m_en/m_we/m_addr/m_wdata  : RAM strobe, write enable, address, write data
//   m_rdata                   : RAM read data, one cycle after a read strobe
//
// rd_own state  | meaning
// --------------+----------------------------------------------
// NONE          | no read data returning this cycle
// IFETCH        | m_rdata this cycle belongs to the fetch port
// DLOAD         | m_rdata this cycle belongs to the load port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  logic              starve_fire;
  rd_own_e           rd_own_d, rd_own_q;
  logic [DATA_W-1:0] i_hold_d, i_hold_q;
  logic [DATA_W-1:0] d_hold_d, d_hold_q;

`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .i_req (i_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt),
    .fire  (starve_fire)
  );
`else
  // Strict data priority: the guard never fires, whatever the limit.
  assign starve_fire = 1'b0 && (STARVE_LIMIT == 0);
`endif

  // Grants are held off entirely during reset so nothing touches the RAM.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !(i_req && starve_fire)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt) begin
      m_addr  = i_addr;
    end
  end

  always_comb begin
    rd_own_d = NONE;
    if (i_gnt) begin
      rd_own_d = IFETCH;
    end else if (d_gnt && !d_we) begin
      rd_own_d = DLOAD;
    end
  end

  // Reset masks the returning read so a grant just before reset never
  // surfaces as rvalid in the reset cycle.
  assign i_rvalid = !reset && (rd_own_q == IFETCH);
  assign d_rvalid = !reset && (rd_own_q == DLOAD);

  always_comb begin
    i_hold_d = i_rvalid ? m_rdata : i_hold_q;
    d_hold_d = d_rvalid ? m_rdata : d_hold_q;
  end

  always_comb begin
    i_rdata = '0;
    d_rdata = '0;
    if (!reset) begin
      i_rdata = i_rvalid ? m_rdata : i_hold_q;
      d_rdata = d_rvalid ? m_rdata : d_hold_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_own_q <= NONE;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      rd_own_q <= rd_own_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed and random traffic against
// a RAM model, and checks every cycle against a transaction-level model of
// the arbiter kept here (grant rule, read owner, per-port last word).
module tb_mem_arbiter;

  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // RAM seen by the DUT (only the low 8 address bits are populated)
  logic [DW-1:0] ram [0:255];
  always @(posedge clock) begin
    if (m_en) begin
      if (m_we) ram[m_addr[7:0]] <= m_wdata;
      else      m_rdata <= ram[m_addr[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mdl_mem [0:255];
  int            own = 0;          // 0 nothing returning, 1 fetch, 2 load
  logic [DW-1:0] own_data = '0;
  logic [DW-1:0] hold_i = '0;
  logic [DW-1:0] hold_d = '0;
  int            scnt = 0;         // data grants taken while fetch waited
  bit            i_pend = 1'b0;
  bit            d_pend = 1'b0;

  function automatic void model_grant(input bit rst, input bit ir, input bit dr, input int cnt,
                                      output bit gi, output bit gd);
    gi = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      if (ir && dr) begin
        if (STARVE_EN && cnt >= LIM) gi = 1'b1;
        else                         gd = 1'b1;
      end else if (ir) begin
        gi = 1'b1;
      end else if (dr) begin
        gd = 1'b1;
      end
    end
  endfunction

  always @(posedge clock) begin
    bit gi, gd;
    model_grant(reset, i_req, d_req, scnt, gi, gd);
    if (reset) begin
      own = 0; hold_i = '0; hold_d = '0; scnt = 0;
      i_pend = 1'b0; d_pend = 1'b0;
    end else begin
      if (own == 1) hold_i = own_data;
      if (own == 2) hold_d = own_data;
      own = 0;
      if (gi) begin
        own = 1;
        own_data = mdl_mem[i_addr[7:0]];
      end else if (gd) begin
        if (d_we) mdl_mem[d_addr[7:0]] = d_wdata;
        else begin
          own = 2;
          own_data = mdl_mem[d_addr[7:0]];
        end
      end
      if (gi || !i_req) scnt = 0;
      else if (gd)      scnt++;
      i_pend = i_req && !gi;
      d_pend = d_req && !gd;
    end
  end

  // Every-cycle comparison, half a period after the active edge.
  always @(negedge clock) begin
    bit gi, gd, vi, vd;
    model_grant(reset, i_req, d_req, scnt, gi, gd);
    vi = !reset && own == 1;
    vd = !reset && own == 2;
    check("i_gnt", i_gnt, gi);
    check("d_gnt", d_gnt, gd);
    check("m_en", m_en, gi | gd);
    check("m_we", m_we, gd & d_we);
    check("i_rvalid", i_rvalid, vi);
    check("d_rvalid", d_rvalid, vd);
    check("i_rdata", i_rdata, reset ? 32'h0 : (vi ? own_data : hold_i));
    check("d_rdata", d_rdata, reset ? 32'h0 : (vd ? own_data : hold_d));
    if (reset) begin
      check("m_addr_rst", m_addr, 32'h0);
      check("m_wdata_rst", m_wdata, 32'h0);
    end else if (gd) begin
      check("m_addr_d", m_addr, d_addr);
      if (d_we) check("m_wdata_d", m_wdata, d_wdata);
    end else if (gi) begin
      check("m_addr_i", m_addr, i_addr);
      check("m_wdata_i", m_wdata, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA5A50000 | i;
      mdl_mem[i] = 32'hA5A50000 | i;
    end
    ram[16]     = 32'h00000013;
    mdl_mem[16] = 32'h00000013;

    // Reset with both requests up: nothing may be granted.
    reset = 1'b1;
    i_req = 1'b1; i_addr = 30'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'h11111111;
    tick(); tick();
    #5;
    check("rst_i_gnt", i_gnt, 32'h0);
    check("rst_d_gnt", d_gnt, 32'h0);
    check("rst_m_en", m_en, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);

    // Single fetch from 0x10.
    tick();
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_addr = 30'h10;
    #5;
    check("f1_i_gnt", i_gnt, 32'h1);
    tick();
    i_req = 1'b0;
    #5;
    check("f1_i_rvalid", i_rvalid, 32'h1);
    check("f1_i_rdata", i_rdata, 32'h00000013);
    tick();
    #5;
    check("f1_i_rvalid_off", i_rvalid, 32'h0);
    check("f1_i_rdata_hold", i_rdata, 32'h00000013);

    // Fetch contends with a store: store first, fetch next cycle.
    tick();
    i_req = 1'b1; i_addr = 30'h11;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
    #5;
    check("st_d_gnt", d_gnt, 32'h1);
    check("st_i_gnt", i_gnt, 32'h0);
    check("st_m_we", m_we, 32'h1);
    tick();
    d_req = 1'b0;
    #5;
    check("st_next_i_gnt", i_gnt, 32'h1);
    check("st_no_d_rvalid", d_rvalid, 32'h0);

    // Store then load of the same word.
    tick();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h30; d_wdata = 32'hCAFEF00D;
    #5;
    check("sl_store_gnt", d_gnt, 32'h1);
    tick();
    d_we = 1'b0;
    #5;
    check("sl_load_gnt", d_gnt, 32'h1);
    tick();
    d_req = 1'b0;
    #5;
    check("sl_d_rvalid", d_rvalid, 32'h1);
    check("sl_d_rdata", d_rdata, 32'hCAFEF00D);

    // Both requests held with continuous loads.
    tick();
    i_req = 1'b1; i_addr = 30'h5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h6;
    for (int k = 0; k < 10; k++) begin
      #5;
      check("starve_i_gnt", i_gnt, (STARVE_EN && (k % 5 == 4)) ? 32'h1 : 32'h0);
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;

    // Load granted, then reset in the following cycle.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h30;
    #5;
    check("rl_d_gnt", d_gnt, 32'h1);
    tick();
    reset = 1'b1; d_req = 1'b0;
    #5;
    check("rl_d_rvalid", d_rvalid, 32'h0);
    check("rl_d_rdata", d_rdata, 32'h0);
    check("rl_i_rdata", i_rdata, 32'h0);
    check("rl_m_en", m_en, 32'h0);
    check("rl_m_addr", m_addr, 32'h0);

    // Alternating I, D, I loads at 1, 2, 3.
    tick();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 30'h1;
    #5;
    check("alt_i1_gnt", i_gnt, 32'h1);
    tick();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2;
    #5;
    check("alt_d2_gnt", d_gnt, 32'h1);
    check("alt_i1_rvalid", i_rvalid, 32'h1);
    check("alt_i1_rdata", i_rdata, 32'hA5A50001);
    tick();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 30'h3;
    #5;
    check("alt_d2_rvalid", d_rvalid, 32'h1);
    check("alt_d2_rdata", d_rdata, 32'hA5A50002);
    check("alt_i_idle", i_rvalid, 32'h0);
    tick();
    i_req = 1'b0;
    #5;
    check("alt_i3_rvalid", i_rvalid, 32'h1);
    check("alt_i3_rdata", i_rdata, 32'hA5A50003);
    check("alt_d_idle", d_rvalid, 32'h0);

    // Random traffic; requests stay up until the model says they were granted.
    for (int n = 0; n < 4000; n++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (i_pend) i_req = 1'b1;
      else        i_req = ($urandom_range(0, 99) < 60);
      i_addr = 30'($urandom_range(0, 63));
      if (d_pend) d_req = 1'b1;
      else        d_req = ($urandom_range(0, 99) < 70);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = 30'($urandom_range(0, 63));
      d_wdata = $urandom;
    end
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port, synchronous-read word RAM between the CPU instruction-fetch port and the CPU load/store port. It replaces the dual-port memory when the design is built with a single-port RAM. It grants at most one access per cycle and returns read data one cycle after the grant. Data accesses have priority; an optional starvation guard bounds how long fetch can be held off.

## Interface
- ADDR_W, 30, word-address width (byte address bits [31:2])
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (guard only; ≥1)

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until granted
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid (cycle after i_gnt)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (cycle after a load grant; never for stores)
- d_rdata  out  DATA_W  load data
- m_en  out  1  RAM access strobe
- m_we  out  1  RAM write enable
- m_addr  out  ADDR_W  RAM word address
- m_wdata  out  DATA_W  RAM write data
- m_rdata  in  DATA_W  RAM read data, valid the cycle after m_en & !m_we

## Operation
- Grant decision is combinational from i_req, d_req and the starvation state:
  - Only one request: grant it.
  - Both requests: grant data, unless the guard has fired (see Configuration).
  - Neither request: no grant.
- m_en = i_gnt | d_gnt. m_addr, m_we and m_wdata are muxed from the granted port. m_we = d_gnt & d_we. m_wdata is 0 when fetch is granted.
- Read-owner register rd_own ∈ {NONE, IFETCH, DLOAD} is loaded every cycle:
  - IFETCH if i_gnt.
  - DLOAD if d_gnt & !d_we.
  - Otherwise NONE.
- i_rvalid = (rd_own == IFETCH); d_rvalid = (rd_own == DLOAD).
- i_rdata and d_rdata show m_rdata while the matching rvalid is high. Otherwise each holds its last returned word, kept in a per-port hold register.
- Stores complete at the grant edge. A load granted the cycle after a store to the same address returns the stored data, because RAM write-before-read ordering is per-cycle.
- A requester changing address or command while its request is high and ungranted is legal; the value sampled in the grant cycle is the one used.

## Timing
- Reset values: i_gnt, d_gnt, m_en, m_we = 0 while reset is high. i_rvalid, d_rvalid = 0. i_rdata, d_rdata, m_addr, m_wdata = 0. rd_own = NONE. Starvation counter = 0.
- Reset mid-operation: a read granted in the reset cycle or the cycle before produces no rvalid. The first rvalid after reset deasserts is no earlier than 2 cycles later.
- Latency: grant is 0 cycles after the request when it wins. Read data arrives exactly 1 cycle after the grant.
- Throughput: 1 access per cycle. Back-to-back grants to alternating ports are allowed; the rvalids follow in the same order.
- Simultaneous fetch and store: the store is granted, and the fetch waits at least 1 cycle.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - Counter increments on each d_gnt while i_req is high.
  - Counter clears on i_gnt or when i_req is low.
  - When the counter reaches STARVE_LIMIT, the next cycle with both requests grants fetch and clears the counter.
- MEM_ARB_STARVE_EN undefined: strict data priority, no counter, and STARVE_LIMIT is ignored.

## Structure
- Package mem_arb_pkg holds the rd_own enum (NONE/IFETCH/DLOAD) and default width constants.
- The optional sub-module is mem_arb_starve_cnt, which contains the counter and fire flag. It is instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Reset, then i_req=1, i_addr=0x10, RAM[0x10]=0x00000013:
  - i_gnt=1 in the same cycle.
  - i_rvalid=1 with i_rdata=0x00000013 in the next cycle.
  - i_rdata holds 0x00000013 afterward.
- Both requests, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF:
  - d_gnt=1, i_gnt=0, m_we=1.
  - Next cycle: i_gnt=1 and no d_rvalid.
- Store 0xCAFEF00D to 0x30, then a load from 0x30 in the following cycle: d_rvalid=1 with d_rdata=0xCAFEF00D two cycles after the store grant.
- With MEM_ARB_STARVE_EN and STARVE_LIMIT=4, hold both requests with continuous loads:
  - Grant pattern repeats D,D,D,D,I.
  - Without the macro, i_gnt stays 0 throughout.
- Assert reset in the cycle after a load grant: d_rvalid=0, and all outputs read 0 in that cycle.
- Alternate I,D,I load grants at addresses 1,2,3: rvalids appear in the same order, each one cycle after its grant, with the matching words.
